// File: rtl/poly_key_synth_pkg.sv
// Shared voice types and width helpers for the polyphonic key synthesiser.
package poly_synth_pkg;

  localparam int KEY_W_MAX = 8;
  localparam int CNT_W_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } voice_state_e;

  typedef struct packed {
    voice_state_e         state;
    logic [KEY_W_MAX-1:0] key;
    logic [CNT_W_MAX-1:0] cnt;
    logic                 phase;
  } voice_t;

  localparam voice_t VOICE_IDLE = '{state: IDLE, key: '0, cnt: '0, phase: 1'b0};

  function automatic int key_w(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

  function automatic int mix_w(input int num_voices);
    return $clog2(num_voices + 1);
  endfunction

endpackage

// File: rtl/poly_key_synth_debounce.sv
// Per-key 2-flop synchroniser and debouncer; emits one-cycle press/release pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;      // debounced level, 1 = released
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_db      <= 1'b1;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db      <= r_sync2;
        r_cnt     <= '0;
        r_press   <= ~r_sync2;
        r_release <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/poly_key_synth.sv
// Polyphonic key synthesiser: debounced keys allocated to square-wave voices,
// mixed to a 1-bit speaker stream by a first-order delta-sigma modulator.
module poly_key_synth
  import poly_synth_pkg::*;
#(
  parameter int NUM_KEYS        = 13,
  parameter int NUM_VOICES      = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PERIOD_W        = 32,
  localparam int KW             = key_w(NUM_KEYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_KEYS-1:0]   KEYBOARD,
  input  logic [PERIOD_W-1:0]   half_period [NUM_KEYS],
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [KW-1:0]         voice_key [NUM_VOICES],
  output logic [7:0]            LED,
  output logic                  spkr,
  output logic [NUM_VOICES-1:0] o_dbg_phase
);

  localparam int MW = mix_w(NUM_VOICES);
  localparam int AW = MW + 1;
  localparam logic [CNT_W_MAX-1:0] CNT_ONE = CNT_W_MAX'(1);

  function automatic logic [CNT_W_MAX-1:0] reload(input logic [PERIOD_W-1:0] hp);
    return (hp == '0) ? '0 : CNT_W_MAX'(hp - PERIOD_W'(1));
  endfunction

  logic [NUM_KEYS-1:0]   w_press;
  logic [NUM_KEYS-1:0]   w_release;
  logic [NUM_KEYS-1:0]   w_req;
  logic [NUM_KEYS-1:0]   w_kgrant;
  logic [NUM_VOICES-1:0] w_vgrant;
  logic [KEY_W_MAX-1:0]  w_sel_key;
  logic [PERIOD_W-1:0]   w_sel_hp;
  logic                  w_alloc;
  logic [PERIOD_W-1:0]   w_cur_hp  [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_cur_rel;
  voice_t                w_nxt     [NUM_VOICES];
  logic [MW-1:0]         w_mix;
  logic [AW-1:0]         w_sum;

  logic [NUM_KEYS-1:0]   r_pend;
  voice_t                r_voice   [NUM_VOICES];
  logic [AW-1:0]         r_acc;
  logic                  r_spkr;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_key_n   (KEYBOARD[k]),
      .o_press   (w_press[k]),
      .o_release (w_release[k])
    );
  end

  // Lowest pending key goes to lowest free voice; a voice freed this cycle
  // only becomes free once its IDLE state is registered.
  always_comb begin
    w_req     = (r_pend | w_press) & ~w_release;
    w_kgrant  = '0;
    w_sel_key = '0;
    w_sel_hp  = '0;
    w_vgrant  = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (w_req[k]) begin
        w_kgrant    = '0;
        w_kgrant[k] = 1'b1;
        w_sel_key   = KEY_W_MAX'(k);
        w_sel_hp    = half_period[k];
      end
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_voice[v].state == IDLE) begin
        w_vgrant    = '0;
        w_vgrant[v] = 1'b1;
      end
    end
    w_alloc = (|w_kgrant) && (|w_vgrant);
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_cur_hp[v]  = '0;
      w_cur_rel[v] = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (r_voice[v].key == KEY_W_MAX'(k)) begin
          w_cur_hp[v]  = half_period[k];
          w_cur_rel[v] = w_release[k];
        end
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_nxt[v] = r_voice[v];
      case (r_voice[v].state)
        IDLE: begin
          if (w_alloc && w_vgrant[v]) begin
            w_nxt[v].state = RUN;
            w_nxt[v].key   = w_sel_key;
            w_nxt[v].phase = 1'b0;
            w_nxt[v].cnt   = reload(w_sel_hp);
          end
        end
        RUN: begin
          if (w_cur_rel[v]) begin
            w_nxt[v] = VOICE_IDLE;
          end else if (w_cur_hp[v] == '0) begin
            w_nxt[v].phase = 1'b0;
            w_nxt[v].cnt   = '0;
          end else if (r_voice[v].cnt == '0) begin
            w_nxt[v].phase = ~r_voice[v].phase;
            w_nxt[v].cnt   = reload(w_cur_hp[v]);
          end else begin
            w_nxt[v].cnt = r_voice[v].cnt - CNT_ONE;
          end
        end
        default: w_nxt[v] = VOICE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_voice[v] <= VOICE_IDLE;
    end else begin
      r_pend <= w_alloc ? (w_req & ~w_kgrant) : w_req;
      for (int v = 0; v < NUM_VOICES; v++) r_voice[v] <= w_nxt[v];
    end
  end

  always_comb begin
    LED   = '0;
    w_mix = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_active[v] = (r_voice[v].state == RUN);
      voice_key[v]    = voice_active[v] ? KW'(r_voice[v].key) : '0;
      o_dbg_phase[v]  = voice_active[v] & r_voice[v].phase;
      w_mix           = w_mix + MW'(o_dbg_phase[v]);
    end
    LED[NUM_VOICES-1:0] = voice_active;
    w_sum = r_acc + AW'(w_mix);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_spkr <= 1'b0;
    end else if (w_sum >= AW'(NUM_VOICES)) begin
      r_acc  <= w_sum - AW'(NUM_VOICES);
      r_spkr <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_spkr <= 1'b0;
    end
  end

  assign spkr = r_spkr;

endmodule

// File: tb/tb_poly_key_synth.sv
// Directed bench for poly_key_synth: allocation table plus tone, mix and reset sequences.
module tb_poly_key_synth;

  localparam int NK = 13;
  localparam int NV = 4;
  localparam int DB = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] kb;
  logic [PW-1:0] hp [NK];
  logic [NV-1:0] voice_active;
  logic [3:0]    vkey [NV];
  logic [7:0]    led;
  logic          spkr;
  logic [NV-1:0] dbg_phase;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [NK-1:0] pressed;
    int            cycles;
    logic [NV-1:0] act;
    logic [15:0]   keys;   // {key3, key2, key1, key0}
  } vec_t;

  vec_t vecs[16];

  poly_key_synth #(
    .NUM_KEYS(NK), .NUM_VOICES(NV), .DEBOUNCE_CYCLES(DB), .PERIOD_W(PW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .KEYBOARD     (kb),
    .half_period  (hp),
    .voice_active (voice_active),
    .voice_key    (vkey),
    .LED          (led),
    .spkr         (spkr),
    .o_dbg_phase  (dbg_phase)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_voices(input string tag, input logic [NV-1:0] act, input logic [15:0] keys);
    check({tag, ".active"}, 32'(voice_active), 32'(act));
    check({tag, ".led"}, 32'(led), {24'd0, 4'd0, act});
    for (int i = 0; i < NV; i++)
      check($sformatf("%s.key%0d", tag, i), 32'(vkey[i]), 32'(keys[i*4 +: 4]));
  endtask

  initial begin
    int ones;

    vecs[0]  = '{13'h0000,  2, 4'h0, 16'h0000};
    vecs[1]  = '{13'h1000,  6, 4'h0, 16'h0000};
    vecs[2]  = '{13'h1000,  1, 4'h1, 16'h000C};
    vecs[3]  = '{13'h0000,  6, 4'h1, 16'h000C};
    vecs[4]  = '{13'h0000,  1, 4'h0, 16'h0000};
    vecs[5]  = '{13'h0802,  7, 4'h1, 16'h0001};
    vecs[6]  = '{13'h0802,  1, 4'h3, 16'h00B1};
    vecs[7]  = '{13'h08AA,  7, 4'h7, 16'h03B1};
    vecs[8]  = '{13'h08AA,  1, 4'hF, 16'h53B1};
    vecs[9]  = '{13'h08AA,  3, 4'hF, 16'h53B1};
    vecs[10] = '{13'h00AA,  6, 4'hF, 16'h53B1};
    vecs[11] = '{13'h00AA,  1, 4'hD, 16'h5301};
    vecs[12] = '{13'h00AA,  1, 4'hF, 16'h5371};
    vecs[13] = '{13'h00A2,  3, 4'hF, 16'h5371};
    vecs[14] = '{13'h00AA, 10, 4'hF, 16'h5371};
    vecs[15] = '{13'h0000,  7, 4'h0, 16'h0000};

    reset_n = 1'b0;
    kb      = '1;
    for (int k = 0; k < NK; k++) hp[k] = PW'(k + 2);
    hp[12] = 3;
    step(3);
    check_voices("in_reset", 4'h0, 16'h0000);
    check("in_reset.spkr", 32'(spkr), 32'd0);
    reset_n = 1'b1;

    // Allocation, saturation, release and glitch table.
    for (int i = 0; i < 16; i++) begin
      kb = ~vecs[i].pressed;
      step(vecs[i].cycles);
      check_voices($sformatf("vec%0d", i), vecs[i].act, vecs[i].keys);
    end

    // Key 12 with half-period 3: phase toggles every 3 cycles after allocation.
    kb = ~13'h1000;
    step(7);
    check_voices("tone.alloc", 4'h1, 16'h000C);
    for (int i = 0; i < 12; i++) exp_q.push_back(32'((i / 3) % 2));
    for (int i = 0; i < 12; i++) begin
      check($sformatf("tone.phase%0d", i), 32'(dbg_phase[0]), exp_q.pop_front());
      step(1);
    end
    kb = '1;
    step(7);
    check_voices("tone.release", 4'h0, 16'h0000);

    // Mute key: half-period 0 holds phase at 0 while the voice is active.
    hp[0] = 0;
    kb = ~13'h0001;
    step(7);
    check_voices("mute.alloc", 4'h1, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("mute.phase%0d", i), 32'(dbg_phase), 32'd0);
    end
    kb = '1;
    step(7);
    check_voices("mute.release", 4'h0, 16'h0000);

    // Two of four voices high: spkr duty exactly 50%.
    hp[4] = 40;
    hp[6] = 40;
    kb = ~13'h0050;
    step(8);
    check_voices("ds.alloc", 4'h3, 16'h0064);
    step(45);
    check("ds.phase", 32'(dbg_phase), 32'h3);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      ones += int'(spkr);
      step(1);
    end
    check("ds.duty", 32'(ones), 32'd10);
    kb = '1;
    step(8);
    check_voices("ds.release", 4'h0, 16'h0000);
    check("ds.spkr_idle", 32'(spkr), 32'd0);

    // Reset while three voices run; keys stay held through reset.
    kb = ~13'h0304;
    step(9);
    check_voices("mr.run", 4'h7, 16'h0982);
    reset_n = 1'b0;
    #1;
    check_voices("mr.reset", 4'h0, 16'h0000);
    check("mr.spkr", 32'(spkr), 32'd0);
    check("mr.phase", 32'(dbg_phase), 32'd0);
    step(3);
    reset_n = 1'b1;
    step(6);
    check_voices("mr.wait", 4'h0, 16'h0000);
    step(1);
    check_voices("mr.first", 4'h1, 16'h0002);
    step(2);
    check_voices("mr.all", 4'h7, 16'h0982);
    kb = '1;
    step(8);
    check_voices("mr.release", 4'h0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
